// File: rtl/lsu_pkg.sv
// Shared FSM state type, RV32 funct3 encodings and store-lane helpers
// for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAM     = 2'd1,
        ST_IO_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1] set means a full word; funct3[0] alone means a halfword.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) || (funct3[1] && (addr_lo != 2'b00));
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] funct3, input logic [1:0] addr_lo);
        if (funct3[1])
            return 4'b1111;
        if (funct3[0])
            return addr_lo[1] ? 4'b1100 : 4'b0011;
        return 4'b0001 << addr_lo;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        if (funct3[1])
            return wdata;
        if (funct3[0])
            return {2{wdata[15:0]}};
        return {4{wdata[7:0]}};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the core and the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rdId;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rdId;
    logic        rsp_err;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rdId, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_rdId, rsp_err
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rdId, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_rdId, rsp_err
    );
endinterface

// File: rtl/lsu_dataram.sv
// Byte-enabled single-port data RAM with registered read (read-before-write).
module lsu_dataram #(
    parameter int    RAM_WORDS = 16384,
    parameter string INIT_FILE = "DATARAM.hex"
) (
    input  logic                         clk,
    input  logic                         i_en,
    input  logic [3:0]                   i_we,
    input  logic [$clog2(RAM_WORDS)-1:0] i_addr,
    input  logic [31:0]                  i_wdata,
    output logic [31:0]                  o_rdata
);

    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b])
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: aligned accesses to an internal data RAM or a
// strobed IO bus with timeout, returned through a valid/ready response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int    RAM_WORDS  = 16384,
    parameter int    IO_BIT     = 22,
    parameter int    IO_TIMEOUT = 255,
    parameter string INIT_FILE  = "DATARAM.hex"
) (
    input  logic                     clk,
    input  logic                     resetn,
    load_store_unit_if.slave         bus,
    output logic [31:0]              IO_mem_addr,
    output logic [31:0]              IO_mem_wdata,
    output logic                     IO_mem_wr,
    output logic                     IO_mem_rd,
    input  logic [31:0]              IO_mem_rdata,
    input  logic                     IO_mem_ready
);

    localparam int          AW       = $clog2(RAM_WORDS);
    localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);

    lsu_state_e  r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_rdId;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_wdata;
    logic        r_io_wr;
    logic        r_io_rd;
    logic [15:0] r_io_cnt;

    logic        w_accept;
    logic        w_is_io;
    logic        w_misaligned;
    logic        w_ram_en;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_rdata;

    assign w_accept     = bus.req_valid && (r_state == ST_IDLE);
    assign w_is_io      = bus.req_addr[IO_BIT];
    assign w_misaligned = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_ram_en     = w_accept && !w_is_io && !w_misaligned;
    assign w_ram_we     = (w_ram_en && bus.req_is_store) ? store_lanes(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;

    lsu_dataram #(
        .RAM_WORDS (RAM_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_dataram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (bus.req_addr[AW+1:2]),
        .i_wdata (store_data(bus.req_funct3, bus.req_wdata)),
        .o_rdata (w_ram_rdata)
    );

    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'd0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'd0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_rdId  <= 5'd0;
            r_funct3    <= 3'd0;
            r_is_store  <= 1'b0;
            r_addr_lo   <= 2'd0;
            r_io_addr   <= 32'd0;
            r_io_wdata  <= 32'd0;
            r_io_wr     <= 1'b0;
            r_io_rd     <= 1'b0;
            r_io_cnt    <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_rsp_rdId  <= bus.req_rdId;
                        r_funct3    <= bus.req_funct3;
                        r_is_store  <= bus.req_is_store;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_rsp_data  <= 32'd0;
                        r_rsp_err   <= w_misaligned;
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (w_is_io) begin
                            r_io_addr  <= bus.req_addr;
                            r_io_wdata <= bus.req_wdata;
                            r_io_wr    <= bus.req_is_store;
                            r_io_rd    <= !bus.req_is_store;
                            r_io_cnt   <= 16'd0;
                            r_state    <= ST_IO_WAIT;
                        end else begin
                            r_state <= ST_RAM;
                        end
                    end
                end
                ST_RAM: begin
                    r_rsp_data  <= r_is_store ? 32'd0 : format_load(w_ram_rdata, r_funct3, r_addr_lo);
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_IO_WAIT: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (IO_mem_ready) begin
                        r_rsp_data  <= r_is_store ? 32'd0 : IO_mem_rdata;
                        r_io_wr     <= 1'b0;
                        r_io_rd     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_io_cnt == TMO_LAST) begin
                        r_rsp_err   <= 1'b1;
                        r_io_wr     <= 1'b0;
                        r_io_rd     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_io_cnt <= r_io_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_rdId  = r_rsp_rdId;
    assign bus.rsp_err   = r_rsp_err;
    assign IO_mem_addr   = r_io_addr;
    assign IO_mem_wdata  = r_io_wdata;
    assign IO_mem_wr     = r_io_wr;
    assign IO_mem_rd     = r_io_rd;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized transactions checked against a byte-addressed
// memory model and an IO timing model.
module tb_load_store_unit;

    localparam int RAM_WORDS = 1024;
    localparam int TMO       = 4;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_wr;
    logic        io_rd;
    logic [31:0] io_rdata;
    logic        io_ready;

    int          checks   = 0;
    int          failures = 0;
    int          txn      = 0;
    logic [7:0]  model_bytes [0:1023];
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(
        .RAM_WORDS  (RAM_WORDS),
        .IO_BIT     (22),
        .IO_TIMEOUT (TMO),
        .INIT_FILE  ("")
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .IO_mem_addr  (io_addr),
        .IO_mem_wdata (io_wdata),
        .IO_mem_wr    (io_wr),
        .IO_mem_rd    (io_rd),
        .IO_mem_rdata (io_rdata),
        .IO_mem_ready (io_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr);
        int          n;
        logic [31:0] v;
        n = size_of(f3);
        v = 32'd0;
        for (int k = 0; k < n; k++)
            v = v | (32'(model_bytes[addr + k]) << (8 * k));
        if (!f3[2] && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Caller is at a negedge; returns at a negedge with the unit idle again.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int io_delay,
                          input logic [31:0] io_rdv, input int hold,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_scnt);
        int   lat;
        int   scnt;
        logic got;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rdId     = rd;
        bus.rsp_ready    = 1'b0;
        io_rdata         = io_rdv;
        io_ready         = 1'b0;
        lat  = 0;
        scnt = 0;
        got  = 1'b0;
        while (!got && lat < 64) begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else if (io_rd || io_wr) begin
                scnt++;
                chk("io_strobe_kind", {30'd0, io_wr, io_rd}, st ? 32'd2 : 32'd1);
                chk("io_addr", io_addr, addr);
                if (st) chk("io_wdata", io_wdata, wdata);
                io_ready = (io_delay > 0 && scnt == io_delay);
            end else begin
                io_ready = 1'b0;
            end
        end
        io_ready = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_latency", lat, exp_lat);
        chk("io_strobe_cycles", scnt, exp_scnt);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_rdId", 32'(bus.rsp_rdId), 32'(rd));
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        txn++;
        $display("txn %0d st=%0d f3=%0d addr=%08h wdata=%08h rd=%0d -> data=%08h err=%0d lat=%0d strobes=%0d",
                 txn, st, f3, addr, wdata, rd, bus.rsp_data, bus.rsp_err, lat, scnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_data", bus.rsp_data, exp_data);
            chk("hold_err", 32'(bus.rsp_err), 32'(exp_err));
            chk("hold_rdId", 32'(bus.rsp_rdId), 32'(rd));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Derives expectations from the access rules, then runs the transaction.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int io_delay,
                       input logic [31:0] io_rd_val, input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_scnt;
        int          n;
        logic [31:0] rdv;
        logic        ok;
        n   = size_of(f3);
        rdv = st ? 32'd0 : io_rd_val;
        if ((addr % n) != 0) begin
            exp_data = 32'd0; exp_err = 1'b1; exp_lat = 1; exp_scnt = 0;
        end else if (addr[22]) begin
            ok       = (io_delay >= 1 && io_delay <= TMO);
            exp_scnt = ok ? io_delay : TMO;
            exp_err  = !ok;
            exp_data = (ok && !st) ? rdv : 32'd0;
            exp_lat  = exp_scnt + 1;
        end else begin
            exp_err  = 1'b0; exp_lat = 2; exp_scnt = 0;
            exp_data = st ? 32'd0 : ref_load(f3, int'(addr));
            if (st)
                for (int k = 0; k < n; k++)
                    model_bytes[int'(addr) + k] = wdata[8*k +: 8];
        end
        do_req(st, f3, addr, wdata, rd, io_delay, rdv, hold, exp_data, exp_err, exp_lat, exp_scnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rdId     = 5'd0;
        bus.rsp_ready    = 1'b0;
        io_rdata         = 32'd0;
        io_ready         = 1'b0;
        for (int i = 0; i < 1024; i++) model_bytes[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_rsp_rdId", 32'(bus.rsp_rdId), 32'd0);
        chk("reset_io_strobes", {30'd0, io_wr, io_rd}, 32'd0);
        chk("reset_io_addr", io_addr, 32'd0);
        chk("reset_io_wdata", io_wdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Give the exercised RAM region known contents.
        for (int w = 0; w < 192; w++)
            run(1'b1, 3'b010, 32'(w * 4), $urandom, 5'($urandom_range(0, 31)), 0, 32'd0, 0);

        run(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 0, 32'd0, 0);
        run(1'b0, 3'b000, 32'h103, 32'd0, 5'd4, 0, 32'd0, 0);
        run(1'b1, 3'b010, 32'h200, 32'h0BADF00D, 5'd0, 0, 32'd0, 0);
        run(1'b1, 3'b001, 32'h202, 32'h00001234, 5'd0, 0, 32'd0, 0);
        run(1'b0, 3'b010, 32'h200, 32'd0, 5'd7, 0, 32'd0, 1);
        run(1'b0, 3'b010, 32'h0040_0000, 32'd0, 5'd9, 3, 32'hA5A5A5A5, 0);
        run(1'b1, 3'b010, 32'h0040_0004, 32'h11223344, 5'd1, 0, 32'd0, 0);
        run(1'b0, 3'b010, 32'h0040_0008, 32'd0, 5'd2, 4, 32'h5A5A0F0F, 0);
        run(1'b0, 3'b001, 32'h101, 32'd0, 5'd5, 0, 32'd0, 5);
        run(1'b0, 3'b010, 32'h100, 32'd0, 5'd6, 0, 32'd0, 0);
        run(1'b0, 3'b100, 32'h103, 32'd0, 5'd8, 0, 32'd0, 0);
        run(1'b0, 3'b101, 32'h102, 32'd0, 5'd8, 0, 32'd0, 0);

        // Reset during IO_WAIT drops strobe and response asynchronously.
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h0040_0010; bus.req_rdId = 5'd12;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("io_wait_strobe_on", 32'(io_rd), 32'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_io_rd", 32'(io_rd), 32'd0);
        chk("async_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("async_reset_io_addr", io_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // A RAM store committed before reset must survive it.
        bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h2F0; bus.req_wdata = 32'h12345678; bus.req_rdId = 5'd13;
        for (int k = 0; k < 4; k++) model_bytes[32'h2F0 + k] = bus.req_wdata[8*k +: 8];
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("ram_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run(1'b0, 3'b010, 32'h2F0, 32'd0, 5'd14, 0, 32'd0, 0);

        for (int t = 0; t < 200; t++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] addr;
            st   = 1'($urandom_range(0, 1));
            f3   = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            addr = ($urandom_range(0, 9) < 2) ? (32'h0040_0000 | 32'($urandom_range(0, 255)))
                                               : 32'($urandom_range(0, 32'h2FC));
            run(st, f3, addr, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 5),
                $urandom, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
